// File: rtl/store_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_pkg
// Size codes, FSM state encoding and store-decoding helpers shared by the
// B-operand store unit and its byte mux.
// Revision: 1.0
// ----------------------------------------------------------------------------
package store_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  // Index of the final beat for a given size (beat count minus one).
  function automatic logic [1:0] last_beat(input logic [1:0] size);
    case (size)
      SIZE_H:  last_beat = 2'd1;
      SIZE_W:  last_beat = 2'd3;
      default: last_beat = 2'd0;
    endcase
  endfunction

  // Illegal size code or a half/word store that is not naturally aligned.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  is_illegal = 1'b0;
      SIZE_H:  is_illegal = lo[0];
      SIZE_W:  is_illegal = (lo != 2'b00);
      default: is_illegal = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_byte_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_byte_mux
// Picks byte [sel] of the latched store word (little-endian beat order).
// Revision: 1.0
// ----------------------------------------------------------------------------
module store_byte_mux (
  input  logic [31:0] word_i,
  input  logic [1:0]  sel_i,
  output logic [7:0]  byte_o
);

  // Byte lane select; beat 0 is the least significant byte.
  always_comb begin
    byte_o = 8'h00;
    case (sel_i)
      2'd0: byte_o = word_i[7:0];
      2'd1: byte_o = word_i[15:8];
      2'd2: byte_o = word_i[23:16];
      2'd3: byte_o = word_i[31:24];
      default: byte_o = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/b_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// b_store_unit
// Drains the latched B operand to a byte-wide memory port for SB/SH/SW,
// one little-endian byte per mem_we/mem_ack handshake.
// Revision: 1.0
// ----------------------------------------------------------------------------
module b_store_unit
  import store_pkg::*;
#(
  parameter int W  = 32,
  parameter int AW = 32
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [1:0]    size_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  b_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  output logic          mem_we_o,
  input  logic          mem_ack_i
);

  state_t        state_q;
  logic [1:0]    beat_q;
  logic [1:0]    beat_d;
  logic [1:0]    last_q;
  logic [AW-1:0] addr_l_q;
  logic [31:0]   data_l_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          we_q;

  // Only the low word of the operand is ever stored.
  assign beat_d = beat_q + 2'd1;

  // Control FSM: latches the request, walks beats on ack, pulses done/err.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      last_q   <= 2'd0;
      addr_l_q <= '0;
      data_l_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (start_i) begin
            addr_l_q <= addr_i;
            data_l_q <= b_data_i[31:0];
            last_q   <= last_beat(size_i);
            beat_q   <= 2'd0;
            if (is_illegal(size_i, addr_i[1:0])) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= WRITE;
              busy_q  <= 1'b1;
              we_q    <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Address/data derive from beat_q, so they hold until the ack edge.
          if (mem_ack_i) begin
            if (beat_q == last_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              we_q    <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        ERR: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  store_byte_mux u_byte_mux (
    .word_i (data_l_q),
    .sel_i  (beat_q),
    .byte_o (mem_wdata_o)
  );

  // Address wraps modulo 2^AW by construction of the adder width.
  assign mem_addr_o = addr_l_q + AW'(beat_q);
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign mem_we_o   = we_q;

endmodule
`default_nettype wire

// File: tb/tb_b_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_b_store_unit
// Self-checking bench for b_store_unit: directed scenarios plus randomized
// stores compared against a byte-list reference model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_b_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic [31:0] addr  = '0;
  logic [31:0] b_data = '0;
  logic        busy, done, err, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Results recorded by the driver for the scenario tasks to judge.
  int r_done_cycle, r_err_cycle, r_done_cnt, r_err_cnt, r_we_seen, r_unstable;
  logic r_timeout, r_busy1;

  logic [39:0] write_log[$];
  logic [39:0] exp_log[$];

  b_store_unit #(.W(32), .AW(32)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (start),
    .size_i      (size),
    .addr_i      (addr),
    .b_data_i    (b_data),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_ack_i   (mem_ack)
  );

  always #5 clock = ~clock;

  // Every accepted beat lands in memory: record {address, byte}.
  always @(posedge clock)
    if (!reset && mem_we && mem_ack) write_log.push_back({mem_addr, mem_wdata});

  // Reference model: a legal store writes 2^size bytes, LSB first, at addr+i.
  function automatic int model_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit model_legal(input logic [1:0] sz, input logic [31:0] a);
    return (sz != 2'b11) && ((a % model_bytes(sz)) == 0);
  endfunction

  task automatic model_build(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    exp_log.delete();
    if (model_legal(sz, a))
      for (int i = 0; i < model_bytes(sz); i++)
        exp_log.push_back({a + 32'(i), d[8*i +: 8]});
  endtask

  // Issue one request and play the memory side; ack after `delay` stall cycles.
  task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           input int delay, input int inj_cycle, input logic [31:0] inj_data);
    int stall;
    logic prev_hold;
    logic [31:0] pa;
    logic [7:0] pw;
    r_done_cycle = -1; r_err_cycle = -1; r_done_cnt = 0; r_err_cnt = 0;
    r_we_seen = 0; r_unstable = 0; r_timeout = 1'b0; r_busy1 = 1'b0;
    stall = 0; prev_hold = 1'b0; pa = '0; pw = '0;
    write_log.delete();
    @(negedge clock);
    size = sz; addr = a; b_data = d; start = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clock);
      start = (cyc == inj_cycle);
      if (cyc == inj_cycle) begin
        b_data = inj_data; addr = a + 32'h40; size = 2'b10;
      end
      if (cyc == 1) r_busy1 = busy;
      if (done) begin r_done_cnt++; if (r_done_cycle < 0) r_done_cycle = cyc; end
      if (err)  begin r_err_cnt++;  if (r_err_cycle < 0)  r_err_cycle = cyc;  end
      if (prev_hold && (!mem_we || mem_addr !== pa || mem_wdata !== pw)) r_unstable++;
      if (mem_we) begin
        r_we_seen++;
        if (stall == delay) begin mem_ack = 1'b1; stall = 0; end
        else begin mem_ack = 1'b0; stall++; end
      end else begin
        mem_ack = 1'b0;
      end
      prev_hold = mem_we && !mem_ack; pa = mem_addr; pw = mem_wdata;
      if (r_done_cycle >= 0 && cyc >= r_done_cycle + 2) break;
      if (r_err_cycle >= 0 && cyc >= r_err_cycle + 2) break;
      if (cyc == 200) r_timeout = 1'b1;
    end
    start = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy, done, err, mem_we, mem_addr, mem_wdata} !== 44'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b we=%b addr=%h wdata=%h, want all zero",
               busy, done, err, mem_we, mem_addr, mem_wdata);
    end
    start = 1'b1; size = 2'b00; addr = 32'h5;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_with_start: got busy=%b we=%b, want 0 0", busy, mem_we);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_start_dropped: got busy=%b we=%b done=%b, want 0 0 0", busy, mem_we, done);
    end
  endtask

  task automatic test_sb;
    run_store(2'b00, 32'h103, 32'hAABBCCDD, 0, 0, '0);
    model_build(2'b00, 32'h103, 32'hAABBCCDD);
    n_checks++;
    if (r_done_cycle !== 2 || r_done_cnt !== 1 || r_timeout) begin
      n_errors++;
      $display("FAIL sb_done: got cycle=%0d count=%0d timeout=%b, want cycle 2 count 1", r_done_cycle, r_done_cnt, r_timeout);
    end
    n_checks++;
    if (r_busy1 !== 1'b1) begin
      n_errors++;
      $display("FAIL sb_busy: got busy=%b at cycle 1, want 1", r_busy1);
    end
    n_checks++;
    if (write_log.size() != 1 || write_log[0] !== exp_log[0]) begin
      n_errors++;
      $display("FAIL sb_write: got %0d writes first=%h, want 1 write %h", write_log.size(),
               (write_log.size() > 0) ? write_log[0] : 40'h0, exp_log[0]);
    end
  endtask

  task automatic test_sw;
    run_store(2'b10, 32'h200, 32'h11223344, 0, 0, '0);
    model_build(2'b10, 32'h200, 32'h11223344);
    n_checks++;
    if (r_done_cycle !== 5 || r_done_cnt !== 1 || r_we_seen !== 4) begin
      n_errors++;
      $display("FAIL sw_timing: got done_cycle=%0d count=%0d we_cycles=%0d, want 5 1 4", r_done_cycle, r_done_cnt, r_we_seen);
    end
    n_checks++;
    if (write_log.size() != exp_log.size()) begin
      n_errors++;
      $display("FAIL sw_count: got %0d writes, want %0d", write_log.size(), exp_log.size());
    end else begin
      for (int i = 0; i < exp_log.size(); i++)
        if (write_log[i] !== exp_log[i]) begin
          n_errors++;
          $display("FAIL sw_beat%0d: got %h, want %h", i, write_log[i], exp_log[i]);
        end
    end
  endtask

  task automatic test_sh_stall;
    run_store(2'b01, 32'h10, 32'hCAFEBEEF, 3, 0, '0);
    model_build(2'b01, 32'h10, 32'hCAFEBEEF);
    n_checks++;
    if (r_unstable !== 0) begin
      n_errors++;
      $display("FAIL sh_stall_stable: got %0d unstable cycles, want 0", r_unstable);
    end
    n_checks++;
    if (write_log.size() != 2 || write_log[0] !== exp_log[0] || write_log[1] !== exp_log[1]) begin
      n_errors++;
      $display("FAIL sh_stall_writes: got %0d writes, want 2 (%h %h)", write_log.size(), exp_log[0], exp_log[1]);
    end
    n_checks++;
    if (r_done_cycle !== 9 || r_done_cnt !== 1) begin
      n_errors++;
      $display("FAIL sh_stall_done: got cycle=%0d count=%0d, want 9 1", r_done_cycle, r_done_cnt);
    end
  endtask

  task automatic test_err;
    logic [1:0]  szs[3]   = '{2'b01, 2'b10, 2'b11};
    logic [31:0] addrs[3] = '{32'h11, 32'h22, 32'h40};
    for (int k = 0; k < 3; k++) begin
      run_store(szs[k], addrs[k], 32'h12345678, 0, 0, '0);
      n_checks++;
      if (r_err_cycle !== 1 || r_err_cnt !== 1 || r_we_seen !== 0 || r_done_cnt !== 0 || write_log.size() != 0) begin
        n_errors++;
        $display("FAIL err_req%0d: got err_cycle=%0d errs=%0d we=%0d dones=%0d writes=%0d, want 1 1 0 0 0",
                 k, r_err_cycle, r_err_cnt, r_we_seen, r_done_cnt, write_log.size());
      end
    end
  endtask

  task automatic test_start_ignored;
    run_store(2'b10, 32'h400, 32'h8899AABB, 0, 2, 32'h01020304);
    model_build(2'b10, 32'h400, 32'h8899AABB);
    n_checks++;
    if (write_log.size() != 4 || r_done_cnt !== 1 || r_done_cycle !== 5) begin
      n_errors++;
      $display("FAIL start_ignored_count: got writes=%0d dones=%0d done_cycle=%0d, want 4 1 5",
               write_log.size(), r_done_cnt, r_done_cycle);
    end else begin
      for (int i = 0; i < 4; i++)
        if (write_log[i] !== exp_log[i]) begin
          n_errors++;
          $display("FAIL start_ignored_beat%0d: got %h, want %h", i, write_log[i], exp_log[i]);
        end
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL start_ignored_idle: got busy=%b we=%b, want 0 0", busy, mem_we);
    end
  endtask

  task automatic test_reset_mid;
    write_log.delete();
    @(negedge clock);
    size = 2'b10; addr = 32'h300; b_data = 32'hDEADBEEF; start = 1'b1;
    @(negedge clock);  // cycle 1: beat 0 presented
    start = 1'b0; mem_ack = 1'b1;
    @(negedge clock);  // cycle 2: beat 1 presented, acked at next edge
    @(negedge clock);  // cycle 3: beat 2 presented, two beats accepted
    reset = 1'b1; mem_ack = 1'b0;
    @(negedge clock);
    n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: got we=%b busy=%b done=%b, want 0 0 0", mem_we, busy, done);
    end
    n_checks++;
    if (write_log.size() != 2) begin
      n_errors++;
      $display("FAIL reset_mid_beats: got %0d writes, want 2", write_log.size());
    end
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_no_pulse: got done=%b err=%b, want 0 0", done, err);
    end
    run_store(2'b00, 32'h7, 32'h000000A5, 0, 0, '0);
    model_build(2'b00, 32'h7, 32'h000000A5);
    n_checks++;
    if (r_done_cycle !== 2 || write_log.size() != 1 || write_log[0] !== exp_log[0]) begin
      n_errors++;
      $display("FAIL reset_mid_recover: got done_cycle=%0d writes=%0d, want 2 1 (%h)",
               r_done_cycle, write_log.size(), exp_log[0]);
    end
  endtask

  task automatic test_random;
    logic [1:0]  sz;
    logic [31:0] a, d;
    int          dly, n;
    for (int it = 0; it < 40; it++) begin
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d   = $urandom();
      dly = $urandom_range(0, 2);
      run_store(sz, a, d, dly, 0, '0);
      model_build(sz, a, d);
      n = model_bytes(sz);
      n_checks++;
      if (model_legal(sz, a)) begin
        if (r_done_cycle !== n * (dly + 1) + 1 || r_done_cnt !== 1 || r_err_cnt !== 0 || write_log.size() != n) begin
          n_errors++;
          $display("FAIL rand%0d_legal: sz=%0d addr=%h got done_cycle=%0d dones=%0d errs=%0d writes=%0d, want %0d 1 0 %0d",
                   it, sz, a, r_done_cycle, r_done_cnt, r_err_cnt, write_log.size(), n * (dly + 1) + 1, n);
        end else begin
          for (int i = 0; i < n; i++)
            if (write_log[i] !== exp_log[i]) begin
              n_errors++;
              $display("FAIL rand%0d_beat%0d: got %h, want %h", it, i, write_log[i], exp_log[i]);
            end
        end
      end else begin
        if (r_err_cycle !== 1 || r_err_cnt !== 1 || r_we_seen !== 0 || r_done_cnt !== 0) begin
          n_errors++;
          $display("FAIL rand%0d_illegal: sz=%0d addr=%h got err_cycle=%0d errs=%0d we=%0d dones=%0d, want 1 1 0 0",
                   it, sz, a, r_err_cycle, r_err_cnt, r_we_seen, r_done_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sw();
    test_sh_stall();
    test_err();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
